// File: rtl/obi_arb_pkg.sv
// Shared types for the two-master OBI data-port arbiter.
// Holds the master index encoding and the arbiter lock-state encoding.
package obi_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int SEL_W       = $clog2(NUM_MASTERS);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic master_e other_master(input master_e m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/obi_route_fifo.sv
// In-order routing FIFO remembering which master owns each outstanding
// slave transaction; pointers wrap modulo DEPTH beside a separate count.
module obi_route_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while the count says valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/obi_data_arb.sv
// Zero-latency round-robin arbiter merging the core data port and the
// coprocessor memory port onto a single OBI slave, with in-order rvalid steering.
module obi_data_arb
    import obi_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic [31:0]           m0_rdata_o,
    output logic                  m0_rvalid_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic [31:0]           m1_rdata_o,
    output logic                  m1_rvalid_o,

    output logic                  s_req_o,
    input  logic                  s_gnt_i,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [31:0]           s_wdata_o,
    input  logic [31:0]           s_rdata_i,
    input  logic                  s_rvalid_i,

    output logic                  err_o
);

    arb_state_e       r_state;
    master_e          r_lock_sel;
    master_e          r_last;
    logic             r_err;

    master_e          w_sel;
    logic             w_sel_req;
    logic             w_hs;
    logic             w_full;
    logic             w_empty;
    logic [SEL_W-1:0] w_head;
    logic             w_rsp_ok;

    // A locked master keeps the bus; otherwise round-robin on conflict.
    always_comb begin
        w_sel = M0;
        if (r_state == ARB_LOCKED)      w_sel = r_lock_sel;
        else if (m0_req_i && m1_req_i)  w_sel = other_master(r_last);
        else if (m1_req_i)              w_sel = M1;
    end

    assign w_sel_req = (w_sel == M1) ? m1_req_i : m0_req_i;
    assign s_req_o   = w_sel_req & ~w_full & rst_ni;
    assign s_addr_o  = (w_sel == M1) ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = (w_sel == M1) ? m1_we_i    : m0_we_i;
    assign s_be_o    = (w_sel == M1) ? m1_be_i    : m0_be_i;
    assign s_wdata_o = (w_sel == M1) ? m1_wdata_i : m0_wdata_i;

    assign w_hs      = s_req_o & s_gnt_i;
    assign m0_gnt_o  = w_hs & (w_sel == M0);
    assign m1_gnt_o  = w_hs & (w_sel == M1);

    // Only rdata is shared; rvalid goes solely to the owner at the FIFO head.
    assign w_rsp_ok    = s_rvalid_i & ~w_empty;
    assign m0_rvalid_o = w_rsp_ok & (master_e'(w_head) == M0);
    assign m1_rvalid_o = w_rsp_ok & (master_e'(w_head) == M1);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = r_err;

    obi_route_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (SEL_W)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_hs),
        .pop_i   (s_rvalid_i),
        .data_i  (SEL_W'(w_sel)),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_lock_sel <= M0;
            r_last     <= M1;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (s_req_o && !s_gnt_i) begin
                        r_state    <= ARB_LOCKED;
                        r_lock_sel <= w_sel;
                    end
                end
                ARB_LOCKED: begin
                    if (!s_req_o || s_gnt_i) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
            if (w_hs) r_last <= w_sel;
            if (s_rvalid_i && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_data_arb.sv
// Self-checking bench for obi_data_arb: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_obi_data_arb;

   localparam int OUTS = 2;
   localparam int AW   = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic          m0_we = 1'b0, m1_we = 1'b0;
   logic [3:0]    m0_be = '0, m1_be = '0;
   logic [31:0]   m0_wdata = '0, m1_wdata = '0;
   logic          s_gnt = 1'b0, s_rvalid = 1'b0;
   logic [31:0]   s_rdata = '0;

   logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [31:0]   m0_rdata_o, m1_rdata_o;
   logic          s_req_o, s_we_o, err_o;
   logic [AW-1:0] s_addr_o;
   logic [3:0]    s_be_o;
   logic [31:0]   s_wdata_o;

   int nChecks = 0;
   int nPass = 0;

   // Reference model state: owners of outstanding transactions in issue order,
   // who won the bus last, who is presented-but-ungranted, and the error flag.
   int route[$];
   int lastWinner = 1;
   int heldMaster = -1;
   bit errModel = 1'b0;

   obi_data_arb #(.OUTSTANDING(OUTS), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
      .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata_o), .m0_rvalid_o(m0_rvalid_o),
      .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
      .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata_o), .m1_rvalid_o(m1_rvalid_o),
      .s_req_o(s_req_o), .s_gnt_i(s_gnt), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else
         nPass++;
   endtask

   // Model compare: outputs are stable mid-cycle; after checking, advance the
   // model to the state the DUT will hold after the coming rising edge.
   always @(negedge clk) begin
      int  winner;
      bit  winReq, expReq, hs, full;
      if (!rst_n) begin
         route.delete();
         lastWinner = 1;
         heldMaster = -1;
         errModel   = 1'b0;
         checkOutput("rst s_req", s_req_o, 0);
         checkOutput("rst gnt", {m0_gnt_o, m1_gnt_o}, 0);
         checkOutput("rst rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
         checkOutput("rst err", err_o, 0);
      end else begin
         full = (route.size() == OUTS);
         if (heldMaster >= 0)       winner = heldMaster;
         else if (m0_req && m1_req) winner = 1 - lastWinner;
         else if (m1_req)           winner = 1;
         else                       winner = 0;
         winReq = (winner == 1) ? m1_req : m0_req;
         expReq = winReq && !full;
         hs     = expReq && s_gnt;

         checkOutput("model s_req", s_req_o, expReq);
         checkOutput("model m0_gnt", m0_gnt_o, hs && winner == 0);
         checkOutput("model m1_gnt", m1_gnt_o, hs && winner == 1);
         if (expReq) begin
            checkOutput("model s_addr", s_addr_o, winner ? m1_addr : m0_addr);
            checkOutput("model s_we", s_we_o, winner ? m1_we : m0_we);
            checkOutput("model s_be", s_be_o, winner ? m1_be : m0_be);
            checkOutput("model s_wdata", s_wdata_o, winner ? m1_wdata : m0_wdata);
         end
         checkOutput("model m0_rvalid", m0_rvalid_o, s_rvalid && route.size() > 0 && route[0] == 0);
         checkOutput("model m1_rvalid", m1_rvalid_o, s_rvalid && route.size() > 0 && route[0] == 1);
         checkOutput("model rdata", {m0_rdata_o, m1_rdata_o}, {s_rdata, s_rdata});
         checkOutput("model err", err_o, errModel);

         if (s_rvalid) begin
            if (route.size() == 0) errModel = 1'b1;
            else void'(route.pop_front());
         end
         heldMaster = (expReq && !s_gnt) ? winner : -1;
         if (hs) begin
            lastWinner = winner;
            route.push_back(winner);
         end
      end
   end

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit r0, input bit r1, input bit g, input bit rv);
      m0_req = r0;
      m1_req = r1;
      s_gnt = g;
      s_rvalid = rv;
   endtask

   task automatic applyReset;
      applyStimulus(0, 0, 0, 0);
      rst_n = 1'b0;
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
   endtask

   initial begin
      bit g0, g1;
      applyReset();

      // Lone m0 read, answered the next cycle.
      m0_addr = 32'h100;
      m0_we = 1'b0;
      applyStimulus(1, 0, 1, 0);
      @(negedge clk);
      checkOutput("t1 m0_gnt", m0_gnt_o, 1);
      checkOutput("t1 s_addr", s_addr_o, 32'h100);
      nextCycle();
      s_rdata = 32'hDEADBEEF;
      applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("t1 m0_rvalid", m0_rvalid_o, 1);
      checkOutput("t1 m0_rdata", m0_rdata_o, 32'hDEADBEEF);
      checkOutput("t1 m1_rvalid", m1_rvalid_o, 0);
      nextCycle();

      // Both request for four cycles: alternating grants, responses in order.
      applyReset();
      m1_addr = 32'h200;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i < 4, i < 4, 1, i > 0);
         @(negedge clk);
         checkOutput("t2 m0_gnt", m0_gnt_o, (i < 4) && (i % 2 == 0));
         checkOutput("t2 m1_gnt", m1_gnt_o, (i < 4) && (i % 2 == 1));
         checkOutput("t2 m0_rvalid", m0_rvalid_o, (i > 0) && (i % 2 == 1));
         checkOutput("t2 m1_rvalid", m1_rvalid_o, (i > 0) && (i % 2 == 0));
         nextCycle();
      end

      // m1 stalled by the slave keeps the bus while m0 starts requesting.
      applyReset();
      m0_addr = 32'h300;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i >= 1, 1, 0, 0);
         @(negedge clk);
         checkOutput("t3 s_addr held", s_addr_o, 32'h200);
         checkOutput("t3 no gnt", {m0_gnt_o, m1_gnt_o}, 0);
         nextCycle();
      end
      applyStimulus(1, 1, 1, 0);
      @(negedge clk);
      checkOutput("t3 m1_gnt", m1_gnt_o, 1);
      checkOutput("t3 s_addr", s_addr_o, 32'h200);
      nextCycle();
      applyStimulus(1, 0, 1, 0);
      @(negedge clk);
      checkOutput("t3 m0_gnt", m0_gnt_o, 1);
      checkOutput("t3 s_addr m0", s_addr_o, 32'h300);
      nextCycle();

      // Full FIFO blocks the third request, even during the pop cycle.
      applyReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 1, i == 3);
         @(negedge clk);
         checkOutput("t4 s_req", s_req_o, (i < 2) || (i == 4));
         checkOutput("t4 m0_gnt", m0_gnt_o, (i < 2) || (i == 4));
         checkOutput("t4 m0_rvalid", m0_rvalid_o, i == 3);
         nextCycle();
      end

      // Stray response sets a sticky error cleared only by reset.
      applyReset();
      applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("t5 no rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t5 err sticky", err_o, 1);
         nextCycle();
      end
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("t5 err cleared", err_o, 0);
      nextCycle();
      rst_n = 1'b1;

      // Reset with two outstanding drops the routing entries.
      applyStimulus(1, 0, 1, 0);
      nextCycle();
      nextCycle();
      rst_n = 1'b0;
      applyStimulus(1, 0, 1, 1);
      @(negedge clk);
      checkOutput("t6 s_req in reset", s_req_o, 0);
      checkOutput("t6 gnt in reset", {m0_gnt_o, m1_gnt_o}, 0);
      checkOutput("t6 rvalid in reset", {m0_rvalid_o, m1_rvalid_o}, 0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("t6 rvalid after", m0_rvalid_o, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t6 err after", err_o, 1);
      nextCycle();

      // Randomized traffic: masters hold requests until granted.
      applyReset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g0 = m0_gnt_o;
         g1 = m1_gnt_o;
         nextCycle();
         if (!m0_req || g0) begin
            m0_req   = ($urandom_range(0, 2) != 0);
            m0_addr  = $urandom;
            m0_we    = $urandom_range(0, 1);
            m0_be    = $urandom_range(0, 15);
            m0_wdata = $urandom;
         end
         if (!m1_req || g1) begin
            m1_req   = ($urandom_range(0, 2) != 0);
            m1_addr  = $urandom;
            m1_we    = $urandom_range(0, 1);
            m1_be    = $urandom_range(0, 15);
            m1_wdata = $urandom;
         end
         s_gnt    = ($urandom_range(0, 3) != 0);
         s_rvalid = (route.size() > 0) && ($urandom_range(0, 2) != 0);
         s_rdata  = $urandom;
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/obi_data_arb.md
OBI_DATA_ARB -- requirements
Module: obi_data_arb

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, max accepted-but-unanswered slave transactions (power of two, 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of all addr ports.
REQ-003 SHALL have ports clk_i  in  1  single clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have per master m in {m0 = core data port, m1 = coprocessor memory port}: mN_req_i in 1; mN_gnt_o out 1; mN_addr_i in ADDR_WIDTH; mN_we_i in 1; mN_be_i in 4; mN_wdata_i in 32; mN_rdata_o out 32; mN_rvalid_o out 1.
REQ-005 SHALL have slave ports s_req_o out 1; s_gnt_i in 1; s_addr_o out ADDR_WIDTH; s_we_o out 1; s_be_o out 4; s_wdata_o out 32; s_rdata_i in 32; s_rvalid_i in 1 (towards mm_ram data port).
REQ-006 SHALL have err_o out 1, sticky protocol-error flag.

Function
REQ-007 SHALL forward one master's address phase at a time: s_req_o = selected mN_req_i AND NOT fifo_full; s_addr/we/be/wdata muxed from the selected master, combinationally.
REQ-008 SHALL drive mN_gnt_o = s_gnt_i AND s_req_o AND (sel == N); the unselected master's gnt SHALL be 0.
REQ-009 SHALL arbitrate round-robin: when both request and no lock, select the master not granted last; single requester selected directly; last-granted pointer resets to m1, so m0 wins the first conflict.
REQ-010 SHALL lock the selection while s_req_o=1 and s_gnt_i=0 (state LOCKED), releasing on the handshake cycle (s_req_o & s_gnt_i), so addr/wdata stay stable until grant.
REQ-011 SHALL update the last-granted pointer only on a slave handshake.
REQ-012 SHALL push the granted master index into an in-order routing FIFO (depth OUTSTANDING) on each handshake.
REQ-013 SHALL route s_rvalid_i/s_rdata_i to the master at the FIFO head and pop in the same cycle; mN_rdata_o SHALL equal s_rdata_i for both masters, only rvalid is steered.
REQ-014 SHALL, when FIFO is full, hold s_req_o=0 and both gnt=0, even if a pop occurs that cycle (no same-cycle bypass); forwarding resumes the next cycle.
REQ-015 SHALL allow simultaneous push and pop when not full; occupancy unchanged.
REQ-016 SHALL, on s_rvalid_i with an empty FIFO, set err_o, assert no mN_rvalid_o, leave the FIFO unchanged; err_o clears only on reset.
REQ-017 SHALL add zero latency on both request and response paths (purely combinational forwarding, sequential state only in arbiter pointer, lock and FIFO).
REQ-018 SHALL wrap FIFO read/write pointers modulo OUTSTANDING with a separate count of width clog2(OUTSTANDING)+1.

Reset
REQ-019 SHALL, while rst_ni=0, reset FIFO empty, lock cleared, last-granted = m1, err_o=0; s_req_o, m0/m1 gnt and rvalid outputs SHALL be 0 during reset.
REQ-020 SHALL, on reset assertion mid-transaction, discard all outstanding routing entries; responses arriving after reset release SHALL trigger REQ-016.

Structure
REQ-021 SHALL place master-index enum (M0, M1) and localparam NUM_MASTERS=2 in shared package obi_arb_pkg.
REQ-022 SHALL implement the routing FIFO as sub-module obi_route_fifo (parameters DEPTH, WIDTH; push, pop, full, empty, head).
REQ-023 SHALL be instantiated in cv32e40p_tb_subsystem between the core data port plus coprocessor port and mm_ram data port.

Verification
REQ-024 SHALL test: m0 read 0x100 alone, s_gnt_i=1, rvalid next cycle data 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid with 0xDEADBEEF, m1_rvalid=0.
REQ-025 SHALL test: m0 and m1 request together for 4 cycles, s_gnt_i=1 -> grants m0,m1,m0,m1; responses steered in the same order.
REQ-026 SHALL test: m1 requests, s_gnt_i=0 for 3 cycles while m0 raises req -> s_addr_o stays m1 address, m1 granted on cycle 4, then m0.
REQ-027 SHALL test: OUTSTANDING=2, three m0 requests, no rvalid -> third blocked (s_req_o=0); after one rvalid, third granted the following cycle.
REQ-028 SHALL test: s_rvalid_i with empty FIFO -> err_o=1 and held until rst_ni=0.
REQ-029 SHALL test: rst_ni pulled low with 2 outstanding -> all outputs 0 immediately; FIFO empty after release.
